alu_op_sequencer: RTL

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

---
 rtl/alu_op_sequencer_pkg.sv | 25 ++
 rtl/alu_seq_fifo.sv | 51 +++++
 rtl/alu_op_sequencer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU operation sequencer: ALU opcodes and FSM states.
// Used by the ALU, the sequencer and its bench.
package alu_op_sequencer_pkg;

  localparam int OPCODE_W = 3;

  typedef enum logic [OPCODE_W-1:0] {
    OP_ADDU = 3'b000,
    OP_ADDS = 3'b001,
    OP_SUBU = 3'b010,
    OP_SUBS = 3'b011,
    OP_AND  = 3'b100,
    OP_OR   = 3'b101,
    OP_XOR  = 3'b110,
    OP_SHR2 = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HOLD    = 2'd3
  } seq_state_e;

endpackage

// File: rtl/alu_seq_fifo.sv
// Request FIFO for the ALU sequencer: DEPTH entries (power of two), combinational head,
// simultaneous push and pop allowed.
module alu_seq_fifo #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [PW:0]      count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/alu_op_sequencer.sv
// Queues ALU requests, issues them to a downstream registered ALU and returns responses
// in order. Optional op_count output when ALU_SEQ_STATS_EN is defined.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int NUMBITS = 16,
  parameter int DEPTH   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NUMBITS-1:0]  in_a,
  input  logic [NUMBITS-1:0]  in_b,
  input  logic [OPCODE_W-1:0] in_opcode,
  output logic [NUMBITS-1:0]  alu_a,
  output logic [NUMBITS-1:0]  alu_b,
  output logic [OPCODE_W-1:0] alu_opcode,
  input  logic [NUMBITS-1:0]  alu_result,
  input  logic                alu_carryout,
  input  logic                alu_overflow,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NUMBITS-1:0]  out_result,
  output logic                out_carry,
  output logic                out_overflow,
  output logic                out_zero,
  output logic [OPCODE_W-1:0] out_opcode,
`ifdef ALU_SEQ_STATS_EN
  output logic [15:0]         op_count,
`endif
  output logic                busy
);
  localparam int ENTRY_W = 2*NUMBITS + OPCODE_W;
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  seq_state_e          state_q, state_d;
  logic                push, pop, load_out;
  logic                fifo_full, fifo_empty;
  logic [CNT_W-1:0]    fifo_count;
  logic [ENTRY_W-1:0]  fifo_rdata;

  logic [NUMBITS-1:0]  alu_a_q, alu_b_q, out_result_q;
  logic [OPCODE_W-1:0] alu_opcode_q, out_opcode_q;
  logic                out_carry_q, out_overflow_q, out_zero_q;

  // in_ready depends only on reset and FIFO occupancy, never on out_ready.
  assign in_ready = reset && !fifo_full;
  assign push     = in_valid && in_ready;

  alu_seq_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata ({in_opcode, in_b, in_a}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (!fifo_empty) state_d = ST_ISSUE;
      ST_ISSUE:   state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_HOLD;
      ST_HOLD:    if (out_ready) state_d = fifo_empty ? ST_IDLE : ST_ISSUE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Popping from HOLD on the handshake edge gives zero-bubble back-to-back issue.
  always_comb begin
    out_valid = 1'b0;
    pop       = 1'b0;
    load_out  = 1'b0;
    case (state_q)
      ST_IDLE:    pop = !fifo_empty;
      ST_CAPTURE: load_out = 1'b1;
      ST_HOLD: begin
        out_valid = 1'b1;
        pop       = out_ready && !fifo_empty;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_opcode_q <= '0;
    end else if (pop) begin
      {alu_opcode_q, alu_b_q, alu_a_q} <= fifo_rdata;
    end
  end

  // Zero flag is derived here from the captured result, not taken from the ALU.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_result_q   <= '0;
      out_carry_q    <= 1'b0;
      out_overflow_q <= 1'b0;
      out_zero_q     <= 1'b0;
      out_opcode_q   <= '0;
    end else if (load_out) begin
      out_result_q   <= alu_result;
      out_carry_q    <= alu_carryout;
      out_overflow_q <= alu_overflow;
      out_zero_q     <= (alu_result == '0);
      out_opcode_q   <= alu_opcode_q;
    end
  end

`ifdef ALU_SEQ_STATS_EN
  logic [15:0] op_count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                      op_count_q <= '0;
    else if (out_valid && out_ready) op_count_q <= op_count_q + 16'd1;
  end

  assign op_count = op_count_q;
`endif

  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_opcode   = alu_opcode_q;
  assign out_result   = out_result_q;
  assign out_carry    = out_carry_q;
  assign out_overflow = out_overflow_q;
  assign out_zero     = out_zero_q;
  assign out_opcode   = out_opcode_q;
  assign busy         = (state_q != ST_IDLE) || (fifo_count != '0);

endmodule
